// File: rtl/hazard_pkg.sv
// Shared encodings and stage payloads for the Tuse/Tnew hazard tracker.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned T_W   = 2;
  localparam int unsigned FWD_W = 2;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam logic [T_W-1:0] TUSE_D    = 2'd0;
  localparam logic [T_W-1:0] TUSE_E    = 2'd1;
  localparam logic [T_W-1:0] TUSE_M    = 2'd2;
  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  localparam logic [T_W-1:0] TNEW_NONE = 2'd0;
  localparam logic [T_W-1:0] TNEW_E    = 2'd1;
  localparam logic [T_W-1:0] TNEW_M    = 2'd2;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'd0;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'd1;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'd2;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    reg_idx_t       a1;
    reg_idx_t       a2;
    reg_idx_t       a3;
    logic [T_W-1:0] tnew;
  } ex_stage_t;

  typedef struct packed {
    reg_idx_t       a2;
    reg_idx_t       a3;
    logic [T_W-1:0] tnew;
  } mem_stage_t;

  // Remaining cycles until the result exists, one stage further down.
  function automatic logic [T_W-1:0] tnew_step(input logic [T_W-1:0] t);
    return (t == TNEW_NONE) ? TNEW_NONE : T_W'(t - 1'b1);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// One operand vs. the producer stages: stall request and nearest-stage forward select.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] a,
  input  logic [T_W-1:0]   tuse,
  input  logic [REG_W-1:0] a3_e,
  input  logic [T_W-1:0]   tnew_e,
  input  logic [REG_W-1:0] a3_m,
  input  logic [T_W-1:0]   tnew_m,
  input  logic [REG_W-1:0] a3_w,
  output logic             stall_c,
  output logic [FWD_W-1:0] fwd_sel_c
);

  always_comb begin
    stall_c   = 1'b0;
    fwd_sel_c = FWD_RF;
    if (a != '0) begin
      if (tuse != TUSE_NONE) begin
        stall_c = ((a3_e == a) && (tnew_e > tuse)) ||
                  ((a3_m == a) && (tnew_m > tuse));
      end
      if ((a3_e == a) && (tnew_e == TNEW_NONE)) begin
        fwd_sel_c = FWD_EX;
      end else if ((a3_m == a) && (tnew_m == TNEW_NONE)) begin
        fwd_sel_c = FWD_MEM;
      end else if (a3_w == a) begin
        fwd_sel_c = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Tracks the hazard descriptor through EX/MEM/WB and derives ID stall plus
// forwarding selects for ID, EX and MEM consumers.
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_a1,
  input  logic [REG_W-1:0] id_a2,
  input  logic [T_W-1:0]   id_a1_use,
  input  logic [T_W-1:0]   id_a2_use,
  input  logic [REG_W-1:0] id_a3,
  input  logic [T_W-1:0]   id_tnew,
  output logic             stall,
  output logic [FWD_W-1:0] fwd_id_rs,
  output logic [FWD_W-1:0] fwd_id_rt,
  output logic [FWD_W-1:0] fwd_ex_rs,
  output logic [FWD_W-1:0] fwd_ex_rt,
  output logic             fwd_mem_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  ex_stage_t        ex_q;
  mem_stage_t       mem_q;
  reg_idx_t         a3_w_q;
  logic [CNT_W-1:0] cnt_q;

  logic stall_rs, stall_rt, stall_ex_rs, stall_ex_rt;

  hazard_cmp u_id_rs (
    .a(id_a1), .tuse(id_a1_use),
    .a3_e(ex_q.a3), .tnew_e(ex_q.tnew),
    .a3_m(mem_q.a3), .tnew_m(mem_q.tnew), .a3_w(a3_w_q),
    .stall_c(stall_rs), .fwd_sel_c(fwd_id_rs)
  );

  hazard_cmp u_id_rt (
    .a(id_a2), .tuse(id_a2_use),
    .a3_e(ex_q.a3), .tnew_e(ex_q.tnew),
    .a3_m(mem_q.a3), .tnew_m(mem_q.tnew), .a3_w(a3_w_q),
    .stall_c(stall_rt), .fwd_sel_c(fwd_id_rt)
  );

  // EX consumers only see MEM/WB producers; Tuse=NONE makes their stall constant 0.
  hazard_cmp u_ex_rs (
    .a(ex_q.a1), .tuse(TUSE_NONE),
    .a3_e('0), .tnew_e(TNEW_NONE),
    .a3_m(mem_q.a3), .tnew_m(mem_q.tnew), .a3_w(a3_w_q),
    .stall_c(stall_ex_rs), .fwd_sel_c(fwd_ex_rs)
  );

  hazard_cmp u_ex_rt (
    .a(ex_q.a2), .tuse(TUSE_NONE),
    .a3_e('0), .tnew_e(TNEW_NONE),
    .a3_m(mem_q.a3), .tnew_m(mem_q.tnew), .a3_w(a3_w_q),
    .stall_c(stall_ex_rt), .fwd_sel_c(fwd_ex_rt)
  );

  assign stall      = stall_rs | stall_rt | stall_ex_rs | stall_ex_rt;
  assign fwd_mem_rt = (mem_q.a2 != '0) && (a3_w_q == mem_q.a2);
  assign stall_cnt  = cnt_q;

  // Stage tracking registers; a stall injects a bubble into EX only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      a3_w_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (stall) begin
        ex_q <= '0;
      end else begin
        ex_q <= ex_stage_t'{a1: id_a1, a2: id_a2, a3: id_a3, tnew: id_tnew};
      end
      mem_q  <= mem_stage_t'{a2: ex_q.a2, a3: ex_q.a3, tnew: tnew_step(ex_q.tnew)};
      a3_w_q <= mem_q.a3;
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed pipeline scenarios plus random traffic vs. an instruction-history model.
module tb_hazard_tracker;
  import hazard_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] id_a1, id_a2, id_a3;
  logic [1:0] id_a1_use, id_a2_use, id_tnew;
  logic stall, fwd_mem_rt;
  logic [1:0] fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // hist[0]=instr in EX, hist[1]=MEM, hist[2]=WB, each as it entered EX.
  typedef struct { int a1; int a2; int a3; int tnew; } rec_t;
  rec_t hist[3];
  int m_cnt;

  hazard_tracker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_a1(id_a1), .id_a2(id_a2), .id_a1_use(id_a1_use), .id_a2_use(id_a2_use),
    .id_a3(id_a3), .id_tnew(id_tnew),
    .stall(stall), .fwd_id_rs(fwd_id_rs), .fwd_id_rt(fwd_id_rt),
    .fwd_ex_rs(fwd_ex_rs), .fwd_ex_rt(fwd_ex_rt), .fwd_mem_rt(fwd_mem_rt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) hist[k] = '{default: 0};
    m_cnt = 0;
  endfunction

  // Cycles still needed before the result of hist[k] exists.
  function automatic int rem(int k);
    return (hist[k].tnew > k) ? hist[k].tnew - k : 0;
  endfunction

  function automatic int m_stall_op(int a, int u);
    if (a == 0 || u == int'(TUSE_NONE)) return 0;
    for (int k = 0; k < 2; k++)
      if (hist[k].a3 == a && rem(k) > u) return 1;
    return 0;
  endfunction

  function automatic int m_stall();
    return m_stall_op(int'(id_a1), int'(id_a1_use)) | m_stall_op(int'(id_a2), int'(id_a2_use));
  endfunction

  function automatic int m_fwd(int a, int first_k);
    if (a == 0) return 0;
    for (int k = first_k; k < 3; k++)
      if (hist[k].a3 == a && rem(k) == 0) return k + 1;
    return 0;
  endfunction

  function automatic int m_fwd_mem();
    return (hist[1].a2 != 0 && hist[2].a3 == hist[1].a2) ? 1 : 0;
  endfunction

  task automatic set_id(input int a1, input int a2, input int u1, input int u2,
                        input int a3, input int tnew);
    id_a1 = 5'(a1); id_a2 = 5'(a2); id_a1_use = 2'(u1); id_a2_use = 2'(u2);
    id_a3 = 5'(a3); id_tnew = 2'(tnew);
    #2;
  endtask

  task automatic tick();
    int s = m_stall();
    @(posedge clk);
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (s != 0) begin
      hist[0] = '{default: 0};
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      hist[0] = '{a1: int'(id_a1), a2: int'(id_a2), a3: int'(id_a3), tnew: int'(id_tnew)};
    end
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    set_id(0, 0, 3, 3, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_id(7, 9, int'(TUSE_D), int'(TUSE_D), 7, int'(TNEW_M));
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_id_rs !== 2'd0 || fwd_id_rt !== 2'd0 || fwd_ex_rs !== 2'd0 ||
        fwd_ex_rt !== 2'd0 || fwd_mem_rt !== 1'b0 || stall_cnt !== '0) begin
      failures++;
      $display("FAIL reset_hold: stall=%0b fid=%0d/%0d fex=%0d/%0d fmem=%0b cnt=%0d, want all 0",
               stall, fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt, fwd_mem_rt, stall_cnt);
    end
    reset_n = 1'b1;
    model_reset();
    set_id(7, 9, int'(TUSE_D), int'(TUSE_D), 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall !== 1'b0 || fwd_id_rs !== 2'd0 || fwd_id_rt !== 2'd0 || fwd_ex_rs !== 2'd0 ||
          fwd_ex_rt !== 2'd0 || fwd_mem_rt !== 1'b0 || stall_cnt !== '0) begin
        failures++;
        $display("FAIL reset_release cyc=%0d: stall=%0b fid=%0d/%0d fex=%0d/%0d cnt=%0d, want all 0",
                 i, stall, fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt, stall_cnt);
      end
      tick();
    end
  endtask

  task automatic test_lw_add();
    apply_reset();
    set_id(0, 0, 3, 3, 8, int'(TNEW_M));
    tick();
    set_id(8, 8, int'(TUSE_E), int'(TUSE_E), 9, int'(TNEW_E));
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL lw_add_stall1: stall=%0b want 1", stall); end
    tick();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL lw_add_stall2: stall=%0b want 0", stall); end
    tick();
    set_id(0, 0, 3, 3, 0, 0);
    // The load has reached WB by the time add is in EX.
    checks++;
    if (fwd_ex_rs !== 2'd3 || fwd_ex_rt !== 2'd3) begin
      failures++; $display("FAIL lw_add_fwd_ex: rs=%0d rt=%0d want 3/3", fwd_ex_rs, fwd_ex_rt);
    end
    checks++;
    if (stall_cnt !== 4'd1) begin failures++; $display("FAIL lw_add_cnt: cnt=%0d want 1", stall_cnt); end
    tick();
  endtask

  task automatic test_lw_beq();
    apply_reset();
    set_id(0, 0, 3, 3, 8, int'(TNEW_M));
    tick();
    set_id(8, 0, int'(TUSE_D), int'(TUSE_NONE), 0, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (stall !== 1'b1) begin failures++; $display("FAIL lw_beq_stall cyc=%0d: stall=%0b want 1", i, stall); end
      tick();
    end
    checks++;
    if (stall !== 1'b0 || fwd_id_rs !== 2'd3) begin
      failures++; $display("FAIL lw_beq_release: stall=%0b fwd_id_rs=%0d want 0/3", stall, fwd_id_rs);
    end
    checks++;
    if (stall_cnt !== 4'd2) begin failures++; $display("FAIL lw_beq_cnt: cnt=%0d want 2", stall_cnt); end
    tick();
  endtask

  task automatic test_jal_jr();
    apply_reset();
    set_id(0, 0, 3, 3, 31, int'(TNEW_NONE));
    tick();
    set_id(31, 0, int'(TUSE_D), int'(TUSE_NONE), 0, 0);
    checks++;
    if (stall !== 1'b0 || fwd_id_rs !== 2'd1) begin
      failures++; $display("FAIL jal_jr: stall=%0b fwd_id_rs=%0d want 0/1", stall, fwd_id_rs);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    apply_reset();
    set_id(1, 0, int'(TUSE_E), int'(TUSE_NONE), 0, int'(TNEW_E));
    tick();
    set_id(0, 0, int'(TUSE_E), int'(TUSE_E), 2, int'(TNEW_E));
    checks++;
    if (stall !== 1'b0 || fwd_id_rs !== 2'd0 || fwd_id_rt !== 2'd0) begin
      failures++; $display("FAIL zero_reg_id: stall=%0b fid=%0d/%0d want 0/0/0", stall, fwd_id_rs, fwd_id_rt);
    end
    tick();
    set_id(0, 0, 3, 3, 0, 0);
    checks++;
    if (fwd_ex_rs !== 2'd0 || fwd_ex_rt !== 2'd0 || fwd_mem_rt !== 1'b0) begin
      failures++; $display("FAIL zero_reg_ex: fex=%0d/%0d fmem=%0b want 0/0/0", fwd_ex_rs, fwd_ex_rt, fwd_mem_rt);
    end
    tick();
  endtask

  task automatic test_sw_wb_fwd();
    apply_reset();
    set_id(1, 0, int'(TUSE_E), int'(TUSE_NONE), 5, int'(TNEW_E));
    tick();
    set_id(0, 0, 3, 3, 0, 0);
    tick();
    set_id(2, 5, int'(TUSE_E), int'(TUSE_M), 0, 0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL sw_stall: stall=%0b want 0", stall); end
    tick();
    set_id(0, 0, 3, 3, 0, 0);
    checks++;
    if (fwd_ex_rt !== 2'd3) begin failures++; $display("FAIL sw_fwd_ex_rt: got=%0d want 3", fwd_ex_rt); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    set_id(0, 0, 3, 3, 8, int'(TNEW_M));
    tick();
    set_id(8, 0, int'(TUSE_D), int'(TUSE_NONE), 0, 0);
    tick();
    checks++;
    if (stall !== 1'b1 || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL mid_stall_pre: stall=%0b cnt=%0d want 1/1", stall, stall_cnt);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_id_rs !== 2'd0 || fwd_ex_rs !== 2'd0 || fwd_ex_rt !== 2'd0 ||
        fwd_mem_rt !== 1'b0 || stall_cnt !== '0) begin
      failures++;
      $display("FAIL mid_stall_reset: stall=%0b fid=%0d fex=%0d/%0d cnt=%0d want all 0",
               stall, fwd_id_rs, fwd_ex_rs, fwd_ex_rt, stall_cnt);
    end
    reset_n = 1'b1;
    model_reset();
    set_id(0, 0, 3, 3, 0, 0);
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      set_id(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      checks++;
      if (stall !== 1'(m_stall())) begin
        failures++; $display("FAIL rnd_stall cyc=%0d got=%0b want=%0d", i, stall, m_stall());
      end
      checks++;
      if (fwd_id_rs !== 2'(m_fwd(int'(id_a1), 0)) || fwd_id_rt !== 2'(m_fwd(int'(id_a2), 0))) begin
        failures++;
        $display("FAIL rnd_fwd_id cyc=%0d got=%0d/%0d want=%0d/%0d", i, fwd_id_rs, fwd_id_rt,
                 m_fwd(int'(id_a1), 0), m_fwd(int'(id_a2), 0));
      end
      checks++;
      if (fwd_ex_rs !== 2'(m_fwd(hist[0].a1, 1)) || fwd_ex_rt !== 2'(m_fwd(hist[0].a2, 1))) begin
        failures++;
        $display("FAIL rnd_fwd_ex cyc=%0d got=%0d/%0d want=%0d/%0d", i, fwd_ex_rs, fwd_ex_rt,
                 m_fwd(hist[0].a1, 1), m_fwd(hist[0].a2, 1));
      end
      checks++;
      if (fwd_mem_rt !== 1'(m_fwd_mem())) begin
        failures++; $display("FAIL rnd_fwd_mem cyc=%0d got=%0b want=%0d", i, fwd_mem_rt, m_fwd_mem());
      end
      checks++;
      if (stall_cnt !== CNT_W'(m_cnt)) begin
        failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", i, stall_cnt, m_cnt);
      end
      tick();
    end
    checks++;
    if (stall_cnt !== CNT_W'(m_cnt) || (m_cnt == CNT_MAX && stall_cnt !== 4'hF)) begin
      failures++; $display("FAIL rnd_cnt_final got=%0d want=%0d", stall_cnt, m_cnt);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lw_add();
    test_lw_beq();
    test_jal_jr();
    test_zero_reg();
    test_sw_wb_fwd();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
